aclint_timer: RTL and testbench
===============================

// Module: aclint_timer
// PURPOSE
//  Parametrised successor of the core-local interrupt controller: a 64-bit mtime counter with one
//  mtimecmp/msip per hart and one supervisor software-interrupt (SETSSIP) doorbell per hart.
//  The time base is selectable at run time: synchronised RTC rising edge, or an internal clk_i prescaler.
//  Sits behind a 32-bit req/gnt register port (bus adapter is external) and drives hart irq lines and timer_o.
// PARAMETERS
//  NR_HARTS        1   number of harts (1..64): mtimecmp/msip/ssip instances
//  SYNC_STAGES     2   rtc_i synchroniser depth (>=2)
//  PRESCALE_WIDTH  16  width of prescaler divisor register and counter
//  PRESCALE_RESET  0   reset value of divisor (tick every DIV+1 clk_i cycles)
// PORTS
//  clk_i        in   1            clock
//  rst_i        in   1            synchronous, active-high reset
//  rtc_i        in   1            asynchronous real-time clock input
//  req_i        in   1            register access request
//  we_i         in   1            1 = write, 0 = read
//  addr_i       in   16           byte offset; bits[1:0] ignored
//  be_i         in   4            write byte enables
//  wdata_i      in   32           write data
//  gnt_o        out  1            request accepted (= req_i, combinational)
//  rvalid_o     out  1            response valid, exactly 1 cycle after an accepted req (reads and writes)
//  rdata_o      out  32           read data (0 for writes/errors)
//  err_o        out  1            unmapped address, qualified by rvalid_o
//  timer_o      out  64           mtime_q
//  timer_irq_o  out  NR_HARTS     machine timer interrupt per hart
//  ipi_o        out  NR_HARTS     machine software interrupt (msip) per hart
//  ssip_o       out  NR_HARTS     one-cycle supervisor software-interrupt pulse per hart
// BEHAVIOUR
//  Map: 0x0000+4i MSIP[i] (bit0 RW, rest RAZ/WI); 0x4000+8i MTIMECMP[i] lo, +4 hi; 0xBFF8 MTIME lo, 0xBFFC hi;
//   0xC000+4i SETSSIP[i] (write bit0=1 -> pulse, reads 0); 0xC800 CTRL (bit0 MODE, bit1 HALT);
//   0xC804 PRESCALE (bits[PRESCALE_WIDTH-1:0]). i >= NR_HARTS or any other offset: err_o=1, RAZ, write ignored.
//  Writes take effect on the clock edge of acceptance; byte enables honoured on MTIME/MTIMECMP/PRESCALE;
//   MSIP/SETSSIP/CTRL use be_i[0] only. Read data registered: rdata_o = register value before a same-cycle write.
//  Reset: mtime=0, mtimecmp[*]=64'hFFFF_FFFF_FFFF_FFFF, msip=0, MODE=0, HALT=0, PRESCALE=PRESCALE_RESET,
//   prescaler counter=0, sync chain=0; outputs rvalid_o/err_o/ssip_o/ipi_o/timer_irq_o=0, rdata_o=0.
//  Tick source: MODE=0 -> rising edge of rtc_i after SYNC_STAGES flops + edge flop (1 tick per RTC period).
//   MODE=1 -> counter increments each clk_i; when counter==PRESCALE, tick and counter<=0 (DIV=0: every cycle).
//   Writing CTRL or PRESCALE clears the prescaler counter; the edge detector keeps running in both modes.
//  HALT=1: ticks are discarded (mtime frozen); bus writes still apply.
//  mtime: tick -> mtime+1, wraps 2^64-1 -> 0 (carry lo->hi). Bus write to MTIME lo/hi in the same cycle as a
//   tick: written bytes take wdata, the tick is dropped for that cycle (no increment of either half).
//  timer_irq_o[i] registered: asserted the cycle after mtime_q >= mtimecmp_q[i] (unsigned 64-bit); level,
//   deasserted one cycle after a write makes the compare false. No irq out of reset (cmp = all ones).
//  ipi_o = msip_q. ssip_o[i] high for exactly one cycle after an accepted SETSSIP[i] write with bit0=1.
//  Back-to-back requests are accepted every cycle; reset mid-transaction drops the pending response.
// TESTING
//  Reset, read MTIMECMP0 lo/hi -> 0xFFFFFFFF each, rvalid 1 cycle after req, timer_irq_o=0, err_o=0.
//  MODE=1, PRESCALE=3, cmp0=10 -> mtime +1 every 4 clk; timer_irq_o[0] rises 1 cycle after mtime==10.
//  MODE=0, rtc_i toggles period 8 clk -> mtime +1 per rtc rising edge, first tick SYNC_STAGES+1 clk after edge.
//  mtime=0x0000_0000_FFFF_FFFF, tick -> reads lo=0, hi=1; write MTIME lo coinciding with tick -> exact wdata.
//  Write SETSSIP1=1 (NR_HARTS=2) -> ssip_o=2'b10 for one cycle; MSIP1=1 -> ipi_o=2'b10 until cleared.
//  Access 0x0008 with NR_HARTS=2, and 0x8000 -> err_o=1, rdata_o=0, no state change; HALT=1 freezes mtime.

Source files
------------

// File: rtl/aclint_timer.sv
// Core-local timer/IPI block: 64-bit mtime with per-hart mtimecmp, msip and SETSSIP doorbells.
// Time base is either a synchronised RTC rising edge or an internal clk_i prescaler.
module aclint_timer #(
    parameter int unsigned NR_HARTS       = 1,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned PRESCALE_WIDTH = 16,
    parameter int unsigned PRESCALE_RESET = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rtc_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [15:0]          addr_i,
    input  logic [3:0]           be_i,
    input  logic [31:0]          wdata_i,
    output logic                 gnt_o,
    output logic                 rvalid_o,
    output logic [31:0]          rdata_o,
    output logic                 err_o,
    output logic [63:0]          timer_o,
    output logic [NR_HARTS-1:0]  timer_irq_o,
    output logic [NR_HARTS-1:0]  ipi_o,
    output logic [NR_HARTS-1:0]  ssip_o
);

    localparam int unsigned WORD_W = 14;
    localparam logic [WORD_W-1:0] CMP_BASE_W  = 14'h1000;
    localparam logic [WORD_W-1:0] MTIME_LO_W  = 14'h2FFE;
    localparam logic [WORD_W-1:0] MTIME_HI_W  = 14'h2FFF;
    localparam logic [WORD_W-1:0] SSIP_BASE_W = 14'h3000;
    localparam logic [WORD_W-1:0] CTRL_W      = 14'h3200;
    localparam logic [WORD_W-1:0] PRESC_W     = 14'h3201;

    logic [SYNC_STAGES-1:0]           rtc_sync_q;
    logic                             rtc_prev_q;
    logic [PRESCALE_WIDTH-1:0]        presc_q, presc_d, pcnt_q, pcnt_d;
    logic                             mode_q, mode_d, halt_q, halt_d;
    logic [63:0]                      mtime_q, mtime_d;
    logic [NR_HARTS-1:0][63:0]        cmp_q, cmp_d;
    logic [NR_HARTS-1:0]              msip_q, msip_d, ssip_q, ssip_d, irq_q, irq_d;
    logic                             rvalid_q, err_q, err_d;
    logic [31:0]                      rdata_q, rdata_d, rd_val;

    logic [WORD_W-1:0]                word;
    logic                             wr, rtc_rise, pre_hit, tick;
    logic [NR_HARTS-1:0]              msip_sel, cmp_lo_sel, cmp_hi_sel, ssip_sel;
    logic                             mtime_lo_sel, mtime_hi_sel, ctrl_sel, presc_sel, hit;
    logic                             unused_addr_bits;

    assign word             = addr_i[15:2];
    assign wr               = req_i & we_i;
    assign unused_addr_bits = ^addr_i[1:0];

    function automatic logic [31:0] be_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] be);
        logic [31:0] res;
        for (int unsigned b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    // Address decode and read-data mux
    always_comb begin
        msip_sel   = '0;
        cmp_lo_sel = '0;
        cmp_hi_sel = '0;
        ssip_sel   = '0;
        rd_val     = '0;
        for (int unsigned i = 0; i < NR_HARTS; i++) begin
            msip_sel[i]   = (word == WORD_W'(i));
            cmp_lo_sel[i] = (word == CMP_BASE_W + WORD_W'(2 * i));
            cmp_hi_sel[i] = (word == CMP_BASE_W + WORD_W'(2 * i + 1));
            ssip_sel[i]   = (word == SSIP_BASE_W + WORD_W'(i));
            if (msip_sel[i])   rd_val = {31'b0, msip_q[i]};
            if (cmp_lo_sel[i]) rd_val = cmp_q[i][31:0];
            if (cmp_hi_sel[i]) rd_val = cmp_q[i][63:32];
        end
        mtime_lo_sel = (word == MTIME_LO_W);
        mtime_hi_sel = (word == MTIME_HI_W);
        ctrl_sel     = (word == CTRL_W);
        presc_sel    = (word == PRESC_W);
        if (mtime_lo_sel) rd_val = mtime_q[31:0];
        if (mtime_hi_sel) rd_val = mtime_q[63:32];
        if (ctrl_sel)     rd_val = {30'b0, halt_q, mode_q};
        if (presc_sel)    rd_val = 32'(presc_q);
        hit = (|msip_sel) | (|cmp_lo_sel) | (|cmp_hi_sel) | (|ssip_sel) |
              mtime_lo_sel | mtime_hi_sel | ctrl_sel | presc_sel;
    end

    // Bus-visible register updates, response data and irq compare
    always_comb begin
        msip_d  = msip_q;
        cmp_d   = cmp_q;
        ssip_d  = '0;
        mode_d  = mode_q;
        halt_d  = halt_q;
        presc_d = presc_q;
        rdata_d = '0;
        err_d   = req_i & ~hit;
        if (req_i && !we_i && hit) begin
            rdata_d = rd_val;
        end
        if (wr) begin
            for (int unsigned i = 0; i < NR_HARTS; i++) begin
                if (msip_sel[i] && be_i[0]) msip_d[i] = wdata_i[0];
                if (cmp_lo_sel[i]) cmp_d[i][31:0]  = be_merge(cmp_q[i][31:0], wdata_i, be_i);
                if (cmp_hi_sel[i]) cmp_d[i][63:32] = be_merge(cmp_q[i][63:32], wdata_i, be_i);
                if (ssip_sel[i])   ssip_d[i] = be_i[0] & wdata_i[0];
            end
            if (ctrl_sel && be_i[0]) begin
                mode_d = wdata_i[0];
                halt_d = wdata_i[1];
            end
            if (presc_sel) begin
                presc_d = PRESCALE_WIDTH'(be_merge(32'(presc_q), wdata_i, be_i));
            end
        end
        for (int unsigned i = 0; i < NR_HARTS; i++) begin
            irq_d[i] = (mtime_q >= cmp_q[i]);
        end
    end

    // Tick generation: RTC edge or prescaler wrap; mtime bus writes win over a same-cycle tick
    always_comb begin
        rtc_rise = rtc_sync_q[SYNC_STAGES-1] & ~rtc_prev_q;
        pre_hit  = (pcnt_q == presc_q);
        tick     = mode_q ? pre_hit : rtc_rise;
        if (wr && (ctrl_sel || presc_sel)) begin
            pcnt_d = '0;
        end else if (mode_q) begin
            pcnt_d = pre_hit ? '0 : pcnt_q + PRESCALE_WIDTH'(1);
        end else begin
            pcnt_d = '0;
        end
        mtime_d = mtime_q;
        if (wr && (mtime_lo_sel || mtime_hi_sel)) begin
            if (mtime_lo_sel) mtime_d[31:0]  = be_merge(mtime_q[31:0], wdata_i, be_i);
            if (mtime_hi_sel) mtime_d[63:32] = be_merge(mtime_q[63:32], wdata_i, be_i);
        end else if (tick && !halt_q) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rtc_sync_q <= '0;
            rtc_prev_q <= 1'b0;
            presc_q    <= PRESCALE_WIDTH'(PRESCALE_RESET);
            pcnt_q     <= '0;
            mode_q     <= 1'b0;
            halt_q     <= 1'b0;
            mtime_q    <= '0;
            cmp_q      <= '1;
            msip_q     <= '0;
            ssip_q     <= '0;
            irq_q      <= '0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            rtc_sync_q <= {rtc_sync_q[SYNC_STAGES-2:0], rtc_i};
            rtc_prev_q <= rtc_sync_q[SYNC_STAGES-1];
            presc_q    <= presc_d;
            pcnt_q     <= pcnt_d;
            mode_q     <= mode_d;
            halt_q     <= halt_d;
            mtime_q    <= mtime_d;
            cmp_q      <= cmp_d;
            msip_q     <= msip_d;
            ssip_q     <= ssip_d;
            irq_q      <= irq_d;
            rvalid_q   <= req_i;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    assign gnt_o       = req_i;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;
    assign timer_o     = mtime_q;
    assign timer_irq_o = irq_q;
    assign ipi_o       = msip_q;
    assign ssip_o      = ssip_q;

endmodule

// File: tb/tb_aclint_timer.sv
// Scoreboard bench for aclint_timer with a two-hart configuration.
module tb_aclint_timer;

    localparam int NH = 2;

    logic          clk = 1'b0;
    logic          rst_i, rtc_i, req_i, we_i;
    logic [15:0]   addr_i;
    logic [3:0]    be_i;
    logic [31:0]   wdata_i;
    logic          gnt_o, rvalid_o, err_o;
    logic [31:0]   rdata_o;
    logic [63:0]   timer_o;
    logic [NH-1:0] timer_irq_o, ipi_o, ssip_o;

    always #5 clk = ~clk;

    aclint_timer #(
        .NR_HARTS(NH), .SYNC_STAGES(2), .PRESCALE_WIDTH(16), .PRESCALE_RESET(0)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .rtc_i(rtc_i), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o), .timer_o(timer_o),
        .timer_irq_o(timer_irq_o), .ipi_o(ipi_o), .ssip_o(ssip_o)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [1:0]  ssip;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model state
    logic [63:0]   m_mtime;
    logic [63:0]   m_cmp[NH];
    logic [NH-1:0] m_msip;
    logic          m_mode, m_halt;
    logic [15:0]   m_presc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mtime = 64'd0;
        for (int i = 0; i < NH; i++) m_cmp[i] = '1;
        m_msip  = '0;
        m_mode  = 1'b0;
        m_halt  = 1'b0;
        m_presc = 16'd0;
    endtask

    function automatic logic [31:0] bm(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    // Returns {err, data} for a read of byte offset a
    function automatic logic [32:0] mread(input logic [15:0] a);
        int o;
        logic [32:0] r;
        o = int'({a[15:2], 2'b00});
        r = {1'b1, 32'h0};
        if (o < 4 * NH) r = {1'b0, 31'b0, m_msip[o / 4]};
        else if (o >= 'h4000 && o < 'h4000 + 8 * NH)
            r = ((o - 'h4000) % 8 == 4) ? {1'b0, m_cmp[(o - 'h4000) / 8][63:32]}
                                         : {1'b0, m_cmp[(o - 'h4000) / 8][31:0]};
        else if (o == 'hBFF8) r = {1'b0, m_mtime[31:0]};
        else if (o == 'hBFFC) r = {1'b0, m_mtime[63:32]};
        else if (o >= 'hC000 && o < 'hC000 + 4 * NH) r = 33'h0;
        else if (o == 'hC800) r = {1'b0, 30'b0, m_halt, m_mode};
        else if (o == 'hC804) r = {1'b0, 16'b0, m_presc};
        return r;
    endfunction

    // Applies a write to the model; returns the expected ssip pulse vector
    function automatic logic [1:0] mwrite(input logic [15:0] a, input logic [3:0] be, input logic [31:0] wd);
        int o, i;
        logic [1:0] s;
        logic [31:0] t;
        o = int'({a[15:2], 2'b00});
        s = 2'b00;
        if (o < 4 * NH) begin
            if (be[0]) m_msip[o / 4] = wd[0];
        end else if (o >= 'h4000 && o < 'h4000 + 8 * NH) begin
            i = (o - 'h4000) / 8;
            if ((o - 'h4000) % 8 == 4) m_cmp[i][63:32] = bm(m_cmp[i][63:32], wd, be);
            else                       m_cmp[i][31:0]  = bm(m_cmp[i][31:0], wd, be);
        end else if (o == 'hBFF8) m_mtime[31:0]  = bm(m_mtime[31:0], wd, be);
        else if (o == 'hBFFC)     m_mtime[63:32] = bm(m_mtime[63:32], wd, be);
        else if (o >= 'hC000 && o < 'hC000 + 4 * NH) begin
            s[(o - 'hC000) / 4] = be[0] & wd[0];
        end else if (o == 'hC800) begin
            if (be[0]) begin
                m_mode = wd[0];
                m_halt = wd[1];
            end
        end else if (o == 'hC804) begin
            t = bm({16'b0, m_presc}, wd, be);
            m_presc = t[15:0];
        end
        return s;
    endfunction

    // Issue one request (leaves req_i asserted so calls can be back-to-back)
    task automatic bus(input logic we, input logic [15:0] a, input logic [3:0] be, input logic [31:0] wd);
        exp_t e;
        logic [32:0] r;
        r      = mread(a);
        e.err  = r[32];
        e.data = we ? 32'h0 : r[31:0];
        e.ssip = (we && !r[32]) ? mwrite(a, be, wd) : 2'b00;
        e.due  = cyc + 1;
        sb_q.push_back(e);
        req_i = 1'b1; we_i = we; addr_i = a; be_i = be; wdata_i = wd;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        req_i = 1'b0; we_i = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 8) begin
            @(posedge clk); #1;
            k++;
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d responses outstanding, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic chk_irq_ipi();
        check("timer_irq", 64'(timer_irq_o), 64'({m_mtime >= m_cmp[1], m_mtime >= m_cmp[0]}));
        check("ipi", 64'(ipi_o), 64'(m_msip));
    endtask

    // Response monitor: pops the scoreboard whenever the DUT presents a response
    always @(negedge clk) begin
        if (rvalid_o) begin
            if (sb_q.size() == 0) begin
                total++; bad++;
                $display("FAIL rvalid: got unexpected response expected none (cycle %0d)", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("rdata", 64'(rdata_o), 64'(mon_e.data));
                check("err", 64'(err_o), 64'(mon_e.err));
                check("ssip", 64'(ssip_o), 64'(mon_e.ssip));
                check("latency", 64'(cyc), 64'(mon_e.due));
            end
        end else if (!rst_i) begin
            check("ssip_idle", 64'(ssip_o), 64'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [15:0] pool[18] = '{16'h0000, 16'h0004, 16'h0008, 16'h0003, 16'h4000, 16'h4004,
                              16'h4008, 16'h400C, 16'h4010, 16'hBFF8, 16'hBFFC, 16'hC000,
                              16'hC004, 16'hC008, 16'hC800, 16'hC804, 16'h8000, 16'hC808};

    initial begin
        logic [31:0] wd;
        logic [15:0] a;
        rst_i = 1'b1; rtc_i = 1'b0; req_i = 1'b0; we_i = 1'b0;
        addr_i = '0; be_i = '0; wdata_i = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;

        // Reset values
        check("rst_rvalid", 64'(rvalid_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_rdata", 64'(rdata_o), 64'd0);
        check("rst_timer", timer_o, 64'd0);
        chk_irq_ipi();
        bus(1'b0, 16'h4000, 4'hF, 32'h0);
        bus(1'b0, 16'h4004, 4'hF, 32'h0);
        idle(1);
        drain();

        // Prescaler mode, divisor 3, compare 10
        bus(1'b1, 16'h4004, 4'hF, 32'h0);
        bus(1'b1, 16'h4000, 4'hF, 32'd10);
        bus(1'b1, 16'hC804, 4'hF, 32'd3);
        bus(1'b1, 16'hC800, 4'h1, 32'd1);
        req_i = 1'b0; we_i = 1'b0;
        for (int j = 0; j < 48; j++) begin
            @(negedge clk);
            check("presc_mtime", timer_o, 64'(j / 4));
            check("presc_irq", 64'(timer_irq_o), 64'({1'b0, j >= 41}));
        end
        @(posedge clk); #1;
        bus(1'b1, 16'hC800, 4'h1, 32'd3);
        bus(1'b1, 16'hBFF8, 4'hF, 32'd5);
        bus(1'b1, 16'hBFFC, 4'hF, 32'd0);
        idle(20);
        check("halt_mtime", timer_o, 64'd5);
        chk_irq_ipi();
        bus(1'b0, 16'hBFF8, 4'hF, 32'h0);
        idle(1);
        drain();

        // RTC mode: one tick per rising edge, three negedges after rtc_i rises
        bus(1'b1, 16'hC800, 4'h1, 32'd0);
        idle(4);
        drain();
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            rtc_i = 1'b1;
            for (int j = 1; j <= 8; j++) begin
                @(negedge clk);
                check("rtc_mtime", timer_o, 64'(5 + p + ((j >= 3) ? 1 : 0)));
                if (j == 4) rtc_i = 1'b0;
            end
        end
        m_mtime = 64'd9;
        @(posedge clk); #1;

        // Carry from low to high word on a single RTC tick
        bus(1'b1, 16'hBFF8, 4'hF, 32'hFFFF_FFFF);
        bus(1'b1, 16'hBFFC, 4'hF, 32'h0);
        idle(2);
        check("carry_pre", timer_o, 64'h0000_0000_FFFF_FFFF);
        rtc_i = 1'b1;
        idle(6);
        rtc_i = 1'b0;
        idle(4);
        m_mtime = 64'h1_0000_0000;
        check("carry_timer", timer_o, m_mtime);
        bus(1'b0, 16'hBFF8, 4'hF, 32'h0);
        bus(1'b0, 16'hBFFC, 4'hF, 32'h0);
        idle(2);
        chk_irq_ipi();
        drain();

        // MTIME write coinciding with a tick: written value exact, tick dropped
        bus(1'b1, 16'hC804, 4'hF, 32'd0);
        bus(1'b1, 16'hC800, 4'h1, 32'd1);
        bus(1'b1, 16'hBFF8, 4'hF, 32'h1234_5678);
        req_i = 1'b0; we_i = 1'b0;
        @(negedge clk);
        check("wr_tick_drop", timer_o, 64'h1_1234_5678);
        @(negedge clk);
        check("wr_tick_next", timer_o, 64'h1_1234_5679);
        @(posedge clk); #1;
        bus(1'b1, 16'hC800, 4'h1, 32'd2);
        bus(1'b1, 16'hBFF8, 4'hF, 32'h0);
        bus(1'b1, 16'hBFFC, 4'hF, 32'h0);
        idle(2);
        drain();

        // Doorbells
        bus(1'b1, 16'hC004, 4'h1, 32'd1);
        bus(1'b1, 16'hC000, 4'h1, 32'd0);
        bus(1'b1, 16'h0004, 4'h1, 32'd1);
        idle(3);
        chk_irq_ipi();
        check("ipi_set", 64'(ipi_o), 64'h2);
        idle(5);
        check("ipi_hold", 64'(ipi_o), 64'h2);
        bus(1'b1, 16'h0004, 4'h1, 32'd0);
        idle(2);
        check("ipi_clr", 64'(ipi_o), 64'h0);
        drain();

        // Unmapped accesses: error, zero data, no state change
        bus(1'b0, 16'h0008, 4'hF, 32'h0);
        bus(1'b1, 16'h0008, 4'hF, 32'h1);
        bus(1'b1, 16'h8000, 4'hF, 32'hDEAD_BEEF);
        bus(1'b0, 16'h8000, 4'hF, 32'h0);
        bus(1'b1, 16'h4010, 4'hF, 32'h0);
        bus(1'b0, 16'h0000, 4'hF, 32'h0);
        bus(1'b0, 16'h0004, 4'hF, 32'h0);
        bus(1'b0, 16'h4008, 4'hF, 32'h0);
        idle(2);
        chk_irq_ipi();
        drain();

        // Randomised register traffic with the counter halted
        for (int n = 0; n < 150; n++) begin
            int len;
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                a  = pool[$urandom_range(0, 17)];
                wd = $urandom;
                if ($urandom_range(0, 1) == 0) wd = 32'($urandom_range(0, 3));
                if (a == 16'hC800) wd = wd | 32'h2;
                bus(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), wd);
            end
            idle(2);
            chk_irq_ipi();
        end
        drain();
        check("rand_timer", timer_o, m_mtime);

        // Reset during a pending request drops its response
        req_i = 1'b1; we_i = 1'b0; addr_i = 16'h4000; rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_drop_rvalid", 64'(rvalid_o), 64'd0);
        check("rst_timer2", timer_o, 64'd0);
        check("rst_ipi2", 64'(ipi_o), 64'd0);
        #1 rst_i = 1'b0; req_i = 1'b0;
        @(posedge clk); #1;
        model_reset();
        bus(1'b0, 16'h4000, 4'hF, 32'h0);
        bus(1'b0, 16'hC800, 4'hF, 32'h0);
        idle(2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
